// File: rtl/sim_run_monitor.sv
// sim_run_monitor
// Run controller and watchdog placed beside the pipelined MIPS core in its
// test benches. It watches the fetch PC and the WB retire strobe and stops the
// run on end of program, hang, timeout or external halt. After an end or halt
// it lets the pipeline drain for a fixed number of cycles. It then raises a
// sticky done flag with a cause code and frozen cycle and retire counters.

module sim_run_monitor #(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] END_ADDR     = PC_W'(32'h0000_4000),
    parameter int              DRAIN_CYCLES = 5,
    parameter int              HANG_LIMIT   = 64,
    parameter int              TIMEOUT      = 100000,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc,
    input  logic             pc_valid,
    input  logic             retire,
    input  logic             halt_req,
    output logic             running,
    output logic             done,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int HW = $clog2(HANG_LIMIT + 1);
    localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [1:0] CAUSE_END     = 2'b00;
    localparam logic [1:0] CAUSE_HANG    = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_HALT    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      cause_lat;
    logic [1:0]      cause_nxt;
    logic [PC_W-1:0] last_pc;
    logic            pc_seen;
    logic [HW-1:0]   hang_cnt;
    logic [HW-1:0]   hang_nxt;
    logic [DW-1:0]   drain_cnt;

    logic [PC_W:0]    pc_plus4;
    logic             end_hit;
    logic             progress;
    logic             hang_hit;
    logic             timeout_hit;
    logic [CNT_W-1:0] cycle_inc;
    logic [CNT_W-1:0] retire_inc;
    logic             counting;
    logic             enter_done;

    // Stop-condition detection: end bound in PC_W+1 bits so pc+4 cannot wrap,
    // progress on a new valid pc, and the saturating hang count for this cycle.
    always_comb begin
        pc_plus4    = {1'b0, pc} + (PC_W + 1)'(4);
        end_hit     = pc_valid && (pc_plus4 >= {1'b0, END_ADDR});
        progress    = pc_valid && (!pc_seen || (pc != last_pc));
        hang_nxt    = hang_cnt;
        if (progress) begin
            hang_nxt = '0;
        end else if (hang_cnt != HW'(HANG_LIMIT)) begin
            hang_nxt = hang_cnt + HW'(1);
        end
        hang_hit    = (hang_nxt == HW'(HANG_LIMIT));
        cycle_inc   = cycle_cnt + CNT_W'(1);
        retire_inc  = retire_cnt + CNT_W'(retire);
        timeout_hit = (cycle_inc == CNT_W'(TIMEOUT));
        counting    = (state == S_RUN) || (state == S_DRAIN);
    end

    // Next-state and cause selection; in RUN the priority is END > HALT > HANG > TIMEOUT.
    always_comb begin
        state_nxt = state;
        cause_nxt = cause_lat;
        unique case (state)
            S_IDLE: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (end_hit) begin
                    state_nxt = S_DRAIN;
                    cause_nxt = CAUSE_END;
                end else if (halt_req) begin
                    state_nxt = S_DRAIN;
                    cause_nxt = CAUSE_HALT;
                end else if (hang_hit) begin
                    state_nxt = S_DONE;
                    cause_nxt = CAUSE_HANG;
                end else if (timeout_hit) begin
                    state_nxt = S_DONE;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_DRAIN: begin
                if ((drain_cnt == '0) || timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        enter_done = (state != S_DONE) && (state_nxt == S_DONE);
    end

    // State register and the internally latched cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cause_lat <= CAUSE_END;
        end else begin
            state     <= state_nxt;
            cause_lat <= cause_nxt;
        end
    end

    // Progress tracking for the hang detector, only active while in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_pc  <= '0;
            pc_seen  <= 1'b0;
            hang_cnt <= '0;
        end else if (state == S_RUN) begin
            hang_cnt <= hang_nxt;
            if (pc_valid) begin
                last_pc <= pc;
                pc_seen <= 1'b1;
            end
        end
    end

    // Drain countdown: loaded on the way into DRAIN, decremented while draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt <= '0;
        end else if ((state == S_RUN) && (state_nxt == S_DRAIN)) begin
            drain_cnt <= DW'(DRAIN_CYCLES);
        end else if ((state == S_DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - DW'(1);
        end
    end

    // Cycle and retire counters run in RUN and DRAIN and wrap freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else if (counting) begin
            cycle_cnt  <= cycle_inc;
            retire_cnt <= retire_inc;
        end
    end

    // Registered status; done and cause only move on the edge into DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            done    <= 1'b0;
            cause   <= 2'b00;
        end else begin
            running <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            if (enter_done) begin
                done  <= 1'b1;
                cause <= cause_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sim_run_monitor.sv
// tb_sim_run_monitor
// Directed bench for sim_run_monitor. Instance a uses default parameters,
// instance b uses DRAIN_CYCLES=0 and TIMEOUT=100; both see the same inputs.
// Cycle 0 is the IDLE cycle right after reset, cycle 1 the first RUN cycle.

module tb_sim_run_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_valid;
    logic        retire;
    logic        halt_req;

    logic        a_running, a_done;
    logic [1:0]  a_cause;
    logic [31:0] a_cycle, a_retire;
    logic        b_running, b_done;
    logic [1:0]  b_cause;
    logic [31:0] b_cycle, b_retire;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sim_run_monitor dut_a (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .retire     (retire),
        .halt_req   (halt_req),
        .running    (a_running),
        .done       (a_done),
        .cause      (a_cause),
        .cycle_cnt  (a_cycle),
        .retire_cnt (a_retire)
    );

    sim_run_monitor #(
        .DRAIN_CYCLES (0),
        .TIMEOUT      (100)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .retire     (retire),
        .halt_req   (halt_req),
        .running    (b_running),
        .done       (b_done),
        .cause      (b_cause),
        .cycle_cnt  (b_cycle),
        .retire_cnt (b_retire)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [31:0] p, input logic rt, input logic h);
        pc_valid = pv;
        pc       = p;
        retire   = rt;
        halt_req = h;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_a_running"}, 32'(a_running), 32'd0);
        checkOutput({tag, "_a_done"},    32'(a_done),    32'd0);
        checkOutput({tag, "_a_cause"},   32'(a_cause),   32'd0);
        checkOutput({tag, "_a_cycle"},   a_cycle,        32'd0);
        checkOutput({tag, "_a_retire"},  a_retire,       32'd0);
        checkOutput({tag, "_b_done"},    32'(b_done),    32'd0);
        checkOutput({tag, "_b_cycle"},   b_cycle,        32'd0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Straight-line fetch from 0x3000; retire trails fetch by 4 cycles.
    // END fires at cycle 1024 (pc 0x3FFC), DRAIN 1025..1030, done at 1031.
    // Instance b times out at cycle 100: retires 5..100 give 96.
    task automatic runStraight(input int last);
        for (int c = 1; c <= last; c++) begin
            step();
            applyStimulus(c <= 1024, 32'h3000 + 32'(4 * (c - 1)), (c >= 5) && (c <= 1028), 1'b0);
            if (c == 1) begin
                checkOutput("s1_first_run", 32'(a_running), 32'd1);
            end
            if (c == 100) begin
                checkOutput("s1_b_run_100", 32'(b_running), 32'd1);
                checkOutput("s1_b_done_100", 32'(b_done), 32'd0);
            end
            if (c == 101) begin
                checkOutput("s1_b_done",   32'(b_done),  32'd1);
                checkOutput("s1_b_cause",  32'(b_cause), 32'd2);
                checkOutput("s1_b_cycle",  b_cycle,      32'd100);
                checkOutput("s1_b_retire", b_retire,     32'd96);
            end
            if (c == 1030) begin
                checkOutput("s1_run_1030",   32'(a_running), 32'd1);
                checkOutput("s1_done_1030",  32'(a_done),    32'd0);
                checkOutput("s1_cause_1030", 32'(a_cause),   32'd0);
            end
            if (c == 1031) begin
                checkOutput("s1_done",   32'(a_done),    32'd1);
                checkOutput("s1_running", 32'(a_running), 32'd0);
                checkOutput("s1_cause",  32'(a_cause),   32'd0);
                checkOutput("s1_retire", a_retire,       32'd1024);
                checkOutput("s1_cycle",  a_cycle,        32'd1030);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);

        // Scenario 1: straight-line program to the end bound.
        doReset();
        checkZero("rst");
        runStraight(1031);

        // Scenario 2: self-jump at 0x3008 from cycle 10; 64 stuck cycles 11..74.
        doReset();
        for (int c = 1; c <= 75; c++) begin
            step();
            applyStimulus(1'b1, (c < 10) ? 32'h2000 + 32'(4 * c) : 32'h3008, 1'b0, 1'b0);
            if (c == 74) begin
                checkOutput("s2_run_74",  32'(a_running), 32'd1);
                checkOutput("s2_done_74", 32'(a_done),    32'd0);
            end
            if (c == 75) begin
                checkOutput("s2_done",    32'(a_done),    32'd1);
                checkOutput("s2_cause",   32'(a_cause),   32'd1);
                checkOutput("s2_cycle",   a_cycle,        32'd74);
                checkOutput("s2_running", 32'(a_running), 32'd0);
                checkOutput("s2_b_cause", 32'(b_cause),   32'd1);
            end
        end

        // Scenario 3a: fetch stalls from cycle 6; 64 stalled cycles 6..69.
        doReset();
        for (int c = 1; c <= 70; c++) begin
            step();
            applyStimulus(c <= 5, 32'h3000 + 32'(4 * c), (c >= 3) && (c <= 7), 1'b0);
            if (c == 69) begin
                checkOutput("s3_run_69", 32'(a_running), 32'd1);
            end
            if (c == 70) begin
                checkOutput("s3_done",   32'(a_done),  32'd1);
                checkOutput("s3_cause",  32'(a_cause), 32'd1);
                checkOutput("s3_cycle",  a_cycle,      32'd69);
                checkOutput("s3_retire", a_retire,     32'd5);
            end
        end

        // Scenario 3b: alternating 0x3000/0x3004 never hangs; b times out.
        doReset();
        for (int c = 1; c <= 101; c++) begin
            step();
            applyStimulus(1'b1, (c % 2 == 1) ? 32'h3000 : 32'h3004, 1'b0, 1'b0);
            if (c == 100) begin
                checkOutput("s3b_b_done_100", 32'(b_done), 32'd0);
            end
            if (c == 101) begin
                checkOutput("s3b_b_done",  32'(b_done),    32'd1);
                checkOutput("s3b_b_cause", 32'(b_cause),   32'd2);
                checkOutput("s3b_b_cycle", b_cycle,        32'd100);
                checkOutput("s3b_a_run",   32'(a_running), 32'd1);
            end
        end

        // Scenario 4: one-cycle halt at cycle 20; a drains 21..26, b drains only 21.
        doReset();
        for (int c = 1; c <= 27; c++) begin
            step();
            applyStimulus(1'b1, (c % 2 == 1) ? 32'h3000 : 32'h3004, 1'b0, c == 20);
            if (c == 21) begin
                checkOutput("s4_b_run_21",  32'(b_running), 32'd1);
                checkOutput("s4_b_done_21", 32'(b_done),    32'd0);
            end
            if (c == 22) begin
                checkOutput("s4_b_done",  32'(b_done),  32'd1);
                checkOutput("s4_b_cause", 32'(b_cause), 32'd3);
                checkOutput("s4_b_cycle", b_cycle,      32'd21);
            end
            if (c == 26) begin
                checkOutput("s4_run_26",   32'(a_running), 32'd1);
                checkOutput("s4_done_26",  32'(a_done),    32'd0);
                checkOutput("s4_cause_26", 32'(a_cause),   32'd0);
            end
            if (c == 27) begin
                checkOutput("s4_done",    32'(a_done),    32'd1);
                checkOutput("s4_running", 32'(a_running), 32'd0);
                checkOutput("s4_cause",   32'(a_cause),   32'd3);
                checkOutput("s4_cycle",   a_cycle,        32'd26);
            end
        end

        // Scenario 5: 0x3FFC with halt in cycle 5 (END wins); halt in DRAIN ignored.
        doReset();
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c < 5) begin
                applyStimulus(1'b1, 32'h3000 + 32'(4 * (c - 1)), 1'b0, 1'b0);
            end else if (c == 5) begin
                applyStimulus(1'b1, 32'h3FFC, 1'b0, 1'b1);
            end else begin
                applyStimulus(1'b0, 32'h0, 1'b0, c == 8);
            end
            if (c == 6) begin
                checkOutput("s5_b_run_6", 32'(b_running), 32'd1);
            end
            if (c == 7) begin
                checkOutput("s5_b_done",  32'(b_done),  32'd1);
                checkOutput("s5_b_cause", 32'(b_cause), 32'd0);
                checkOutput("s5_b_cycle", b_cycle,      32'd6);
            end
            if (c == 11) begin
                checkOutput("s5_done_11", 32'(a_done), 32'd0);
            end
            if (c == 12) begin
                checkOutput("s5_done",  32'(a_done),  32'd1);
                checkOutput("s5_cause", 32'(a_cause), 32'd0);
                checkOutput("s5_cycle", a_cycle,      32'd11);
            end
        end

        // Scenario 6: reset pulse mid-DRAIN, then the straight-line run again.
        doReset();
        runStraight(1027);
        checkOutput("s6_in_drain", 32'(a_running), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        step();
        checkZero("s6_rst");
        reset = 1'b0;
        cyc   = 0;
        runStraight(1031);

        // Scenario 7: pc 0xFFFF_FFFC must end without wrapping.
        doReset();
        for (int c = 1; c <= 8; c++) begin
            step();
            applyStimulus(c == 1, 32'hFFFF_FFFC, 1'b0, 1'b0);
            if (c == 3) begin
                checkOutput("s7_b_done",  32'(b_done),  32'd1);
                checkOutput("s7_b_cause", 32'(b_cause), 32'd0);
            end
            if (c == 8) begin
                checkOutput("s7_done",  32'(a_done),  32'd1);
                checkOutput("s7_cause", 32'(a_cause), 32'd0);
                checkOutput("s7_cycle", a_cycle,      32'd7);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
